// File: rtl/one_cycle_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : one_cycle_cpu_pkg
// Brief    : Opcodes, instruction field positions and flag indices shared by
//            the single-cycle core and its ALU.
// Revision : 1.0 - initial release
// ============================================================================
package one_cycle_cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_MOV  = 4'h4,
        OP_OUT  = 4'h5,
        OP_JMP  = 4'h6,
        OP_JZ   = 4'h7,
        OP_HLT  = 4'hF
    } opcode_e;

    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int IMM_SEL = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 9;
    localparam int SPARE   = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Opcode 0000 with I=0 is the NOP encoding, so ADDI only counts with I set.
    function automatic logic writes_flags(input logic [3:0] op, input logic imm_sel);
        return ((op == OP_ADDI) && imm_sel) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : cpu_alu
// Brief    : Combinational ALU: add / subtract-with-borrow / and / pass-b,
//            producing the result and {N,Z,C}.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_alu
    import one_cycle_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic [2:0]        o_flags
);

    logic [DATA_W:0] w_wide;

    always_comb begin
        w_wide = '0;
        case (i_op)
            OP_ADDI, OP_ADD: w_wide = {1'b0, i_a} + {1'b0, i_b};
            // The extra MSB of the wrapped difference is the borrow.
            OP_SUB:          w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:          w_wide = {1'b0, i_a & i_b};
            default:         w_wide = {1'b0, i_b};
        endcase
        o_result         = w_wide[DATA_W-1:0];
        o_flags          = '0;
        o_flags[FLAG_N]  = w_wide[DATA_W-1];
        o_flags[FLAG_Z]  = (w_wide[DATA_W-1:0] == '0);
        o_flags[FLAG_C]  = w_wide[DATA_W];
    end

endmodule
`default_nettype wire

// File: rtl/one_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : one_cycle_cpu
// Brief    : Single-cycle 8-bit core with 4-entry register file, externally
//            programmed 256x16 instruction memory, LED bank and halt flag.
// Revision : 1.0 - initial release
// ============================================================================
module one_cycle_cpu
    import one_cycle_cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                boton,
    input  logic [15:0]         data_in,
    input  logic [7:0]          inst_add,
    input  logic                isntruction_wenable,
    input  logic [1:0]          reg_address,
    input  logic                btnLEDS,
    output logic [2:0]          Flags,
    output logic [DATA_W-1:0]   registro,
    output logic [DATA_W-1:0]   LEDS,
    output logic                ledsito
);

    logic [INSTR_W-1:0]       imem_q [IMEM_DEPTH];
    logic [7:0]               pc_q, pc_d;
    logic [3:0][DATA_W-1:0]   regs_q, regs_d;
    logic [2:0]               flags_q, flags_d;
    logic [DATA_W-1:0]        out_q, out_d;
    logic                     halted_q, halted_d;

    logic [INSTR_W-1:0]       w_instr;
    logic [3:0]               w_op;
    logic                     w_imm_sel;
    logic [1:0]               w_rd, w_rs;
    logic [7:0]               w_imm;
    logic [DATA_W-1:0]        w_src;
    logic [DATA_W-1:0]        w_alu_result;
    logic [2:0]               w_alu_flags;
    logic                     w_unused_spare;

    assign w_instr        = imem_q[pc_q];
    assign w_op           = w_instr[OP_MSB:OP_LSB];
    assign w_imm_sel      = w_instr[IMM_SEL];
    assign w_rd           = w_instr[RD_MSB:RD_LSB];
    assign w_rs           = w_instr[RS_MSB:RS_LSB];
    assign w_imm          = w_instr[IMM_MSB:IMM_LSB];
    assign w_unused_spare = w_instr[SPARE];
    assign w_src          = w_imm_sel ? DATA_W'(w_imm) : regs_q[w_rs];

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_op),
        .i_a      (regs_q[w_rd]),
        .i_b      (w_src),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    always_comb begin
        pc_d     = pc_q;
        regs_d   = regs_q;
        flags_d  = flags_q;
        out_d    = out_q;
        halted_d = halted_q;
        if (isntruction_wenable) begin
            // Programming stalls the core and rewinds it to the first word.
            pc_d     = 8'h00;
            halted_d = 1'b0;
        end else if (!halted_q) begin
            pc_d = pc_q + 8'h01;
            if (writes_flags(w_op, w_imm_sel)) begin
                regs_d[w_rd] = w_alu_result;
                flags_d      = w_alu_flags;
            end
            case (w_op)
                OP_MOV: regs_d[w_rd] = w_src;
                OP_OUT: out_d        = w_src;
                OP_JMP: pc_d         = w_imm;
                OP_JZ:  if (flags_q[FLAG_Z]) pc_d = w_imm;
                OP_HLT: begin
                    pc_d     = pc_q;
                    halted_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (boton) begin
            pc_q     <= '0;
            regs_q   <= '0;
            flags_q  <= '0;
            out_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            regs_q   <= regs_d;
            flags_q  <= flags_d;
            out_q    <= out_d;
            halted_q <= halted_d;
        end
    end

    // Instruction store has no reset; a reset cycle only blocks the write.
    always_ff @(posedge clk) begin
        if (!boton && isntruction_wenable) begin
            imem_q[inst_add] <= data_in;
        end
    end

    assign registro = regs_q[reg_address];
    assign LEDS     = btnLEDS ? out_q : DATA_W'(pc_q);
    assign Flags    = flags_q;
    assign ledsito  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_one_cycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_one_cycle_cpu
// Brief    : Directed and random program checks of one_cycle_cpu against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_one_cycle_cpu;

    logic        clk = 1'b0;
    logic        boton;
    logic [15:0] data_in;
    logic [7:0]  inst_add;
    logic        isntruction_wenable;
    logic [1:0]  reg_address;
    logic        btnLEDS;
    logic [2:0]  Flags;
    logic [7:0]  registro;
    logic [7:0]  LEDS;
    logic        ledsito;

    one_cycle_cpu #(.IMEM_DEPTH(256), .DATA_W(8)) dut (
        .clk                 (clk),
        .boton               (boton),
        .data_in             (data_in),
        .inst_add            (inst_add),
        .isntruction_wenable (isntruction_wenable),
        .reg_address         (reg_address),
        .btnLEDS             (btnLEDS),
        .Flags               (Flags),
        .registro            (registro),
        .LEDS                (LEDS),
        .ledsito             (ledsito)
    );

    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference machine state
    logic [15:0] m_mem [256];
    logic [7:0]  m_r   [4];
    int          m_pc;
    bit          m_n, m_z, m_c, m_halt;
    logic [7:0]  m_out;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [15:0] ins;
        int op, rd, rs, imm, a, s, res, nxt;
        bit iv, wr;
        if (boton) begin
            m_pc = 0; m_n = 0; m_z = 0; m_c = 0; m_out = 8'h00; m_halt = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        end else if (isntruction_wenable) begin
            m_mem[inst_add] = data_in;
            m_pc = 0;
            m_halt = 0;
        end else if (!m_halt) begin
            ins = m_mem[m_pc];
            op  = int'(ins[15:12]);
            iv  = ins[11];
            rd  = int'(ins[10:9]);
            rs  = int'(ins[7:6]);
            imm = int'(ins[7:0]);
            a   = int'(m_r[rd]);
            s   = iv ? imm : int'(m_r[rs]);
            nxt = (m_pc + 1) % 256;
            wr  = 0;
            res = 0;
            case (op)
                0:  if (iv) begin res = a + s; m_c = (res > 255); res = res % 256; wr = 1; end
                1:  begin res = a + s; m_c = (res > 255); res = res % 256; wr = 1; end
                2:  begin res = a - s; m_c = (res < 0); if (res < 0) res += 256; wr = 1; end
                3:  begin res = a & s; m_c = 0; wr = 1; end
                4:  m_r[rd] = 8'(s);
                5:  m_out = 8'(s);
                6:  nxt = imm;
                7:  if (m_z) nxt = imm;
                15: begin nxt = m_pc; m_halt = 1; end
                default: ;
            endcase
            if (wr) begin
                m_r[rd] = 8'(res);
                m_n = (res >= 128);
                m_z = (res == 0);
            end
            m_pc = nxt;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            reg_address = 2'(a);
            #1;
            check($sformatf("%s.r%0d", tag, a), registro, m_r[a]);
        end
        check({tag, ".flags"}, {5'b0, Flags}, {5'b0, m_n, m_z, m_c});
        btnLEDS = 1'b0;
        #1;
        check({tag, ".pc"}, LEDS, 8'(m_pc));
        btnLEDS = 1'b1;
        #1;
        check({tag, ".out"}, LEDS, m_out);
        check({tag, ".halt"}, {7'b0, ledsito}, {7'b0, m_halt});
    endtask

    task automatic write_word(input logic [7:0] addr, input logic [15:0] word);
        isntruction_wenable = 1'b1;
        inst_add = addr;
        data_in  = word;
        tick();
        isntruction_wenable = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        isntruction_wenable = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            check_all(tag);
        end
    endtask

    task automatic check_reg(input string tag, input int a, input logic [7:0] exp);
        reg_address = 2'(a);
        #1;
        check(tag, registro, exp);
    endtask

    task automatic check_pc(input string tag, input logic [7:0] exp);
        btnLEDS = 1'b0;
        #1;
        check(tag, LEDS, exp);
    endtask

    task automatic load_demo();
        logic [15:0] demo [6];
        demo = '{16'h4810, 16'h4A12, 16'h4C14, 16'h4E16, 16'h0880, 16'h500A};
        for (int i = 0; i < 6; i++) write_word(8'(i), demo[i]);
    endtask

    task automatic check_demo(input string tag);
        logic [7:0] exp_r [4];
        exp_r = '{8'h90, 8'h12, 8'h14, 8'h16};
        for (int a = 0; a < 4; a++) check_reg($sformatf("%s.r%0d", tag, a), a, exp_r[a]);
        check({tag, ".flags"}, {5'b0, Flags}, 8'b0000_0100);
        btnLEDS = 1'b1;
        #1;
        check({tag, ".leds"}, LEDS, 8'h90);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        // Keep halts rare so random programs run for a while.
        if (w[15:12] == 4'hF && $urandom_range(3) != 0) w[15:12] = 4'h4;
        return w;
    endfunction

    initial begin
        boton = 1'b1; isntruction_wenable = 1'b0; data_in = '0; inst_add = '0;
        reg_address = '0; btnLEDS = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;

        tick();
        check_all("reset");
        check_pc("reset.pc_const", 8'h00);
        check({"reset.flags_const"}, {5'b0, Flags}, 8'h00);
        boton = 1'b0;

        for (int i = 0; i < 256; i++) write_word(8'(i), 16'h0000);

        // Program-and-run
        load_demo();
        run(6, "demo");
        check_demo("demo_const");

        // Stall while programming with a valid program in memory
        boton = 1'b1; tick(); boton = 1'b0;
        for (int k = 0; k < 3; k++) begin
            write_word(8'h00, 16'h4810);
            check_all("stall");
            check_pc("stall.pc_const", 8'h00);
            check_reg("stall.r0_const", 0, 8'h00);
        end

        // Carry/zero then JZ
        write_word(8'h00, 16'h4AFF);
        write_word(8'h01, 16'h0A01);
        write_word(8'h02, 16'h7810);
        run(2, "carry");
        check_reg("carry.r1_const", 1, 8'h00);
        check("carry.flags_const", {5'b0, Flags}, 8'b0000_0011);
        run(1, "jz");
        check_pc("jz.pc_const", 8'h10);

        // Halt and release via programming mode
        write_word(8'h00, 16'h0000);
        write_word(8'h01, 16'h0000);
        write_word(8'h02, 16'h0000);
        write_word(8'h03, 16'hF000);
        run(4, "halt");
        run(2, "halted");
        check_pc("halt.pc_const", 8'h03);
        check("halt.led_const", {7'b0, ledsito}, 8'h01);
        write_word(8'h40, 16'h0000);
        check_all("unhalt");
        check_pc("unhalt.pc_const", 8'h00);
        check("unhalt.led_const", {7'b0, ledsito}, 8'h00);

        // Reset mid-run, then the same program reruns
        load_demo();
        run(3, "pre_rst");
        boton = 1'b1; tick(); boton = 1'b0;
        check_all("mid_rst");
        check_pc("mid_rst.pc_const", 8'h00);
        check_reg("mid_rst.r1_const", 1, 8'h00);
        btnLEDS = 1'b1; #1;
        check("mid_rst.out_const", LEDS, 8'h00);
        run(6, "rerun");
        check_demo("rerun_const");

        // PC wrap
        write_word(8'h00, 16'h68FF);
        write_word(8'hFF, 16'h0000);
        run(1, "wrap_a");
        check_pc("wrap.pc_ff", 8'hFF);
        run(1, "wrap_b");
        check_pc("wrap.pc_00", 8'h00);

        // Random programs with occasional resets
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 256; i++) write_word(8'(i), rand_word());
            for (int k = 0; k < 150; k++) begin
                boton = ($urandom_range(63) == 0);
                tick();
                boton = 1'b0;
                check_all($sformatf("rand%0d", round));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
